fmap_stream_tx: RTL and testbench

- Transmitter end of the activation AXI4-Stream path.
- Reads a feature-map tile from an on-chip buffer with a synchronous read port and emits it as an AXI4-Stream.
- Asserts tlast on the final beat of each line and fully honours m_axis_tready backpressure.
- Feeds the activation stages (ReLU, ReLU6, h-swish, sigmoid) from line/tile buffers; one transfer is launched per start pulse.

---
 rtl/fmap_stream_tx.sv | 180 ++++++++++++++++++
 tb/tb_fmap_stream_tx.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmap_stream_tx.sv
// fmap_stream_tx: reads a feature-map tile from a synchronous-read buffer
// and emits it as an AXI4-Stream, one line per tlast, with full backpressure.
// Optional: define FMAP_STREAM_TX_TUSER_SOF_EN to add m_axis_tuser, a
// start-of-frame flag on the first beat of each transfer.
module fmap_stream_tx #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 12,
   parameter int LEN_WIDTH  = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  line_len,
   input  logic [LEN_WIDTH-1:0]  num_lines,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast
`ifdef FMAP_STREAM_TX_TUSER_SOF_EN
   ,
   output logic                  m_axis_tuser
`endif
);

   localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE = 1;
   localparam logic [LEN_WIDTH-1:0]   LEN_ONE  = 1;
   localparam logic [2*LEN_WIDTH-1:0] TOT_ONE  = 1;

   typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

   state_t                  state, state_nx;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [LEN_WIDTH-1:0]    len_q;
   logic [LEN_WIDTH-1:0]    beat_cnt;
   logic [2*LEN_WIDTH-1:0]  remaining;
   logic                    inflight;
   logic                    infl_last;
   logic [1:0]              count;
   logic [1:0]              occ;
   logic                    wr_ptr, rd_ptr;
   logic [DATA_WIDTH-1:0]   buf_data [2];
   logic                    buf_last [2];
   logic                    issue, hs, byp, fifo_push, fifo_pop, beat_last;
   logic                    src_mem;
`ifdef FMAP_STREAM_TX_TUSER_SOF_EN
   logic                    first_q;
   logic                    infl_sof;
   logic                    buf_sof [2];
`endif

   // occupancy = buffered entries plus the read whose data lands this cycle
   assign occ       = count + {1'b0, inflight};
   assign issue     = (state == READ) && (occ < 2'd2);
   assign beat_last = (beat_cnt == (len_q - LEN_ONE));
   assign src_mem   = (count == 2'd0);
   assign m_axis_tvalid = (count != 2'd0) | inflight;
   assign hs        = m_axis_tvalid & m_axis_tready;
   // bypass: buffer empty, fresh read data goes straight out
   assign byp       = src_mem & inflight & m_axis_tready;
   assign fifo_push = inflight & ~byp;
   assign fifo_pop  = (count != 2'd0) & m_axis_tready;

   assign mem_rd_en    = issue;
   assign mem_rd_addr  = addr;
   assign m_axis_tdata = (src_mem && inflight) ? mem_rd_data : buf_data[rd_ptr];
   assign m_axis_tlast = (src_mem && inflight) ? infl_last   : buf_last[rd_ptr];
`ifdef FMAP_STREAM_TX_TUSER_SOF_EN
   assign m_axis_tuser = (src_mem && inflight) ? infl_sof    : buf_sof[rd_ptr];
`endif

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // next-state and status outputs
   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state)
         IDLE: begin
            // zero-length transfers pass through DRAIN so done lands two cycles after start
            if (start) begin
               if ((line_len == '0) || (num_lines == '0)) state_nx = DRAIN;
               else                                       state_nx = READ;
            end
         end
         READ: begin
            busy = 1'b1;
            if (issue && (remaining == TOT_ONE)) state_nx = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            // leave as soon as the last beat handshakes so done follows it directly
            if ((occ == 2'd0) || ((occ == 2'd1) && hs)) state_nx = FINISH;
         end
         FINISH: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // operand latch, address/beat/total counters and in-flight read tag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr      <= '0;
         len_q     <= '0;
         beat_cnt  <= '0;
         remaining <= '0;
         inflight  <= 1'b0;
         infl_last <= 1'b0;
`ifdef FMAP_STREAM_TX_TUSER_SOF_EN
         first_q   <= 1'b0;
         infl_sof  <= 1'b0;
`endif
      end else begin
         inflight <= issue;
         if (issue) begin
            infl_last <= beat_last;
`ifdef FMAP_STREAM_TX_TUSER_SOF_EN
            infl_sof  <= first_q;
`endif
         end
         if ((state == IDLE) && start) begin
            addr      <= base_addr;
            len_q     <= line_len;
            beat_cnt  <= '0;
            remaining <= {{LEN_WIDTH{1'b0}}, line_len} * {{LEN_WIDTH{1'b0}}, num_lines};
`ifdef FMAP_STREAM_TX_TUSER_SOF_EN
            first_q   <= 1'b1;
`endif
         end else if (issue) begin
            addr      <= addr + ADDR_ONE;
            beat_cnt  <= beat_last ? '0 : (beat_cnt + LEN_ONE);
            remaining <= remaining - TOT_ONE;
`ifdef FMAP_STREAM_TX_TUSER_SOF_EN
            first_q   <= 1'b0;
`endif
         end
      end
   end

   // two-entry skid buffer catching read data that cannot leave immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         for (int unsigned i = 0; i < 2; i++) begin
            buf_data[i] <= '0;
            buf_last[i] <= 1'b0;
`ifdef FMAP_STREAM_TX_TUSER_SOF_EN
            buf_sof[i]  <= 1'b0;
`endif
         end
      end else begin
         if (fifo_push) begin
            buf_data[wr_ptr] <= mem_rd_data;
            buf_last[wr_ptr] <= infl_last;
`ifdef FMAP_STREAM_TX_TUSER_SOF_EN
            buf_sof[wr_ptr]  <= infl_sof;
`endif
            wr_ptr <= ~wr_ptr;
         end
         if (fifo_pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, fifo_push} - {1'b0, fifo_pop};
      end
   end

endmodule

// File: tb/tb_fmap_stream_tx.sv
// Directed self-checking bench for fmap_stream_tx. Buffer word = address.
module tb_fmap_stream_tx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [11:0] base_addr = '0;
   logic [11:0] line_len = '0;
   logic [11:0] num_lines = '0;
   logic        busy, done, mem_rd_en;
   logic [11:0] mem_rd_addr;
   logic [15:0] mem_rd_data = '0;
   logic [15:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b0;
   logic        m_axis_tlast;
   logic        tuser_w;
`ifdef FMAP_STREAM_TX_TUSER_SOF_EN
   logic        m_axis_tuser;
   assign tuser_w = m_axis_tuser;
`else
   assign tuser_w = 1'b0;
`endif

   fmap_stream_tx #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .LEN_WIDTH(12)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .line_len(line_len), .num_lines(num_lines), .busy(busy), .done(done),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
`ifdef FMAP_STREAM_TX_TUSER_SOF_EN
      , .m_axis_tuser(m_axis_tuser)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // synchronous-read buffer model
   always @(posedge clk) if (mem_rd_en) mem_rd_data <= {4'h0, mem_rd_addr};

   // monitor state
   logic        mon_clr = 1'b0;
   int          nb = 0, nrd = 0, first_rd = -1, first_vld = -1;
   int          done_n = 0, done_at = -1, stab_err = 0, outst_err = 0, busy_done_err = 0;
   logic [15:0] bd[$];
   logic        bl[$];
   logic        bu[$];
   int          bc[$];
   logic        prev_stall = 1'b0;
   logic [15:0] pd = '0;
   logic        pl = 1'b0, pu = 1'b0;

   // record beats, read issues, done pulses and stall stability
   always @(negedge clk) begin
      if (mon_clr) begin
         nb = 0; nrd = 0; first_rd = -1; first_vld = -1; done_n = 0; done_at = -1;
         stab_err = 0; outst_err = 0; busy_done_err = 0; prev_stall = 1'b0;
         bd.delete(); bl.delete(); bu.delete(); bc.delete();
      end else begin
         if (mem_rd_en) begin
            if (nrd - nb >= 2) outst_err++;
            if (first_rd < 0) first_rd = cyc;
            nrd++;
         end
         if (m_axis_tvalid && first_vld < 0) first_vld = cyc;
         if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== pd ||
                            m_axis_tlast !== pl || tuser_w !== pu)) stab_err++;
         prev_stall = m_axis_tvalid && !m_axis_tready;
         pd = m_axis_tdata; pl = m_axis_tlast; pu = tuser_w;
         if (m_axis_tvalid && m_axis_tready) begin
            bd.push_back(m_axis_tdata); bl.push_back(m_axis_tlast);
            bu.push_back(tuser_w); bc.push_back(cyc);
            nb++;
         end
         if (done) begin
            done_n++; done_at = cyc;
            if (busy) busy_done_err++;
         end
      end
   end

   int   s_cyc = 0;
   logic tmo = 1'b0;

   function automatic logic rdy(input int mode, input int k);
      case (mode)
         1:       return (k % 4 == 0) || (k % 4 == 3);
         2:       return !(k >= 2 && k <= 4);
         default: return 1'b1;
      endcase
   endfunction

   task automatic clear_mon();
      mon_clr = 1'b1;
      @(negedge clk); #1;
      mon_clr = 1'b0;
      @(posedge clk); #1;
   endtask

   // launch one transfer and run until a few cycles past done (bounded)
   task automatic drive_xfer(input logic [11:0] b, input logic [11:0] ll,
                             input logic [11:0] nl, input int mode, input int extra_at);
      int after;
      clear_mon();
      tmo = 1'b0;
      base_addr = b; line_len = ll; num_lines = nl;
      m_axis_tready = rdy(mode, 0);
      start = 1'b1;
      @(negedge clk);
      s_cyc = cyc;
      after = -1;
      for (int k = 1; k < 400; k++) begin
         @(posedge clk); #1;
         start = (k == extra_at);
         if (k == extra_at) begin
            base_addr = 12'h100; line_len = 12'd1; num_lines = 12'd1;
         end
         m_axis_tready = rdy(mode, k);
         if (after < 0 && done_n > 0) after = k;
         if (after >= 0 && k - after >= 6) break;
      end
      start = 1'b0;
      m_axis_tready = 1'b1;
      if (after < 0) tmo = 1'b1;
   endtask

   task automatic test_reset();
      #2;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
      total++; if (mem_rd_en !== 1'b0) begin bad++; $display("FAIL rst_rd_en got=%b want=0", mem_rd_en); end
      total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%b want=0", m_axis_tvalid); end
      total++; if (m_axis_tlast !== 1'b0) begin bad++; $display("FAIL rst_tlast got=%b want=0", m_axis_tlast); end
      total++; if (mem_rd_addr !== 12'h000) begin bad++; $display("FAIL rst_addr got=%h want=000", mem_rd_addr); end
      total++; if (m_axis_tdata !== 16'h0000) begin bad++; $display("FAIL rst_tdata got=%h want=0000", m_axis_tdata); end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
   endtask

   task automatic test_basic();
      drive_xfer(12'h010, 12'd4, 12'd2, 0, 0);
      total++; if (tmo !== 1'b0) begin bad++; $display("FAIL basic_timeout got=%b want=0", tmo); end
      total++; if (nb !== 8) begin bad++; $display("FAIL basic_beats got=%0d want=8", nb); end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (i >= nb || bd[i] !== 16'h0010 + 16'(i)) begin
            bad++; $display("FAIL basic_data[%0d] got=%h want=%h", i, (i < nb) ? bd[i] : 16'hxxxx, 16'h0010 + 16'(i));
         end
         total++;
         if (i >= nb || bl[i] !== (i == 3 || i == 7)) begin
            bad++; $display("FAIL basic_last[%0d] got=%b want=%b", i, (i < nb) ? bl[i] : 1'bx, (i == 3 || i == 7));
         end
      end
      total++; if (first_rd !== s_cyc + 1) begin bad++; $display("FAIL basic_first_rd got=%0d want=%0d", first_rd, s_cyc + 1); end
      total++; if (first_vld !== s_cyc + 2) begin bad++; $display("FAIL basic_first_vld got=%0d want=%0d", first_vld, s_cyc + 2); end
      total++; if (nb == 8 && bc[7] - bc[0] !== 7) begin bad++; $display("FAIL basic_no_bubble got=%0d want=7", bc[7] - bc[0]); end
      total++; if (done_at !== s_cyc + 10) begin bad++; $display("FAIL basic_done_cyc got=%0d want=%0d", done_at, s_cyc + 10); end
      total++; if (done_n !== 1) begin bad++; $display("FAIL basic_done_cnt got=%0d want=1", done_n); end
      total++; if (busy_done_err !== 0) begin bad++; $display("FAIL basic_busy_at_done got=%0d want=0", busy_done_err); end
   endtask

   task automatic test_backpressure();
      drive_xfer(12'h010, 12'd4, 12'd2, 1, 0);
      total++; if (tmo !== 1'b0) begin bad++; $display("FAIL bp_timeout got=%b want=0", tmo); end
      total++; if (nb !== 8) begin bad++; $display("FAIL bp_beats got=%0d want=8", nb); end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (i >= nb || bd[i] !== 16'h0010 + 16'(i) || bl[i] !== (i == 3 || i == 7)) begin
            bad++; $display("FAIL bp_beat[%0d] got=%h/%b want=%h/%b", i, (i < nb) ? bd[i] : 16'hxxxx,
                            (i < nb) ? bl[i] : 1'bx, 16'h0010 + 16'(i), (i == 3 || i == 7));
         end
      end
      total++; if (stab_err !== 0) begin bad++; $display("FAIL bp_stable got=%0d want=0", stab_err); end
      total++; if (outst_err !== 0) begin bad++; $display("FAIL bp_outstanding got=%0d want=0", outst_err); end
      total++; if (nb == 8 && done_at !== bc[7] + 1) begin bad++; $display("FAIL bp_done_cyc got=%0d want=%0d", done_at, bc[7] + 1); end
      total++; if (done_n !== 1) begin bad++; $display("FAIL bp_done_cnt got=%0d want=1", done_n); end
   endtask

   task automatic test_wrap();
      logic [15:0] wexp [4];
      wexp[0] = 16'h0FFE; wexp[1] = 16'h0FFF; wexp[2] = 16'h0000; wexp[3] = 16'h0001;
      drive_xfer(12'hFFE, 12'd4, 12'd1, 0, 0);
      total++; if (nb !== 4) begin bad++; $display("FAIL wrap_beats got=%0d want=4", nb); end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (i >= nb || bd[i] !== wexp[i] || bl[i] !== (i == 3)) begin
            bad++; $display("FAIL wrap_beat[%0d] got=%h/%b want=%h/%b", i, (i < nb) ? bd[i] : 16'hxxxx,
                            (i < nb) ? bl[i] : 1'bx, wexp[i], (i == 3));
         end
      end
   endtask

   task automatic test_zero_len();
      drive_xfer(12'h020, 12'd4, 12'd0, 0, 0);
      total++; if (nb !== 0) begin bad++; $display("FAIL zero_beats got=%0d want=0", nb); end
      total++; if (first_vld !== -1) begin bad++; $display("FAIL zero_tvalid got=%0d want=-1", first_vld); end
      total++; if (nrd !== 0) begin bad++; $display("FAIL zero_reads got=%0d want=0", nrd); end
      total++; if (done_at !== s_cyc + 2) begin bad++; $display("FAIL zero_done_cyc got=%0d want=%0d", done_at, s_cyc + 2); end
      total++; if (done_n !== 1) begin bad++; $display("FAIL zero_done_cnt got=%0d want=1", done_n); end
   endtask

   task automatic test_start_while_busy();
      drive_xfer(12'h010, 12'd4, 12'd2, 0, 4);
      total++; if (nb !== 8) begin bad++; $display("FAIL swb_beats got=%0d want=8", nb); end
      total++; if (done_n !== 1) begin bad++; $display("FAIL swb_done_cnt got=%0d want=1", done_n); end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (i >= nb || bd[i] !== 16'h0010 + 16'(i) || bl[i] !== (i == 3 || i == 7)) begin
            bad++; $display("FAIL swb_beat[%0d] got=%h/%b want=%h/%b", i, (i < nb) ? bd[i] : 16'hxxxx,
                            (i < nb) ? bl[i] : 1'bx, 16'h0010 + 16'(i), (i == 3 || i == 7));
         end
      end
   endtask

   task automatic test_reset_mid();
      logic reached;
      clear_mon();
      base_addr = 12'h030; line_len = 12'd4; num_lines = 12'd2;
      m_axis_tready = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      reached = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk); #1;
         if (nb >= 3) begin reached = 1'b1; break; end
      end
      total++; if (reached !== 1'b1) begin bad++; $display("FAIL rstmid_3beats got=%0d want=3", nb); end
      rst_n = 1'b0;
      #1;
      total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rstmid_tvalid got=%b want=0", m_axis_tvalid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", done); end
      total++; if (mem_rd_en !== 1'b0) begin bad++; $display("FAIL rstmid_rd_en got=%b want=0", mem_rd_en); end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      total++; if (done_n !== 0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=0", done_n); end
      total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rstmid_idle_tvalid got=%b want=0", m_axis_tvalid); end
      drive_xfer(12'h030, 12'd4, 12'd2, 0, 0);
      total++; if (nb !== 8) begin bad++; $display("FAIL rstmid_fresh_beats got=%0d want=8", nb); end
      total++; if (done_n !== 1) begin bad++; $display("FAIL rstmid_fresh_done got=%0d want=1", done_n); end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (i >= nb || bd[i] !== 16'h0030 + 16'(i) || bl[i] !== (i == 3 || i == 7)) begin
            bad++; $display("FAIL rstmid_beat[%0d] got=%h/%b want=%h/%b", i, (i < nb) ? bd[i] : 16'hxxxx,
                            (i < nb) ? bl[i] : 1'bx, 16'h0030 + 16'(i), (i == 3 || i == 7));
         end
      end
   endtask

`ifdef FMAP_STREAM_TX_TUSER_SOF_EN
   task automatic test_sof();
      drive_xfer(12'h040, 12'd3, 12'd2, 2, 0);
      total++; if (nb !== 6) begin bad++; $display("FAIL sof_beats got=%0d want=6", nb); end
      for (int i = 0; i < 6; i++) begin
         total++;
         if (i >= nb || bu[i] !== (i == 0) || bd[i] !== 16'h0040 + 16'(i) || bl[i] !== (i == 2 || i == 5)) begin
            bad++; $display("FAIL sof_beat[%0d] got=%b want=%b", i, (i < nb) ? bu[i] : 1'bx, (i == 0));
         end
      end
      total++; if (nb > 0 && bc[0] !== s_cyc + 5) begin bad++; $display("FAIL sof_stall_cyc got=%0d want=%0d", bc[0], s_cyc + 5); end
      total++; if (stab_err !== 0) begin bad++; $display("FAIL sof_stable got=%0d want=0", stab_err); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_zero_len();
      test_start_while_busy();
      test_reset_mid();
`ifdef FMAP_STREAM_TX_TUSER_SOF_EN
      test_sof();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule
